mdio_arbiter: RTL and testbench

- Shares one MII management (MDIO) engine among NREQ independent requesters, e.g. the boot-time PHY configuration sequencer, the link-status poller and the debug switch interface.
- Accepts one command at a time using round-robin arbitration and drives the engine's strobe/stall command port.
- Waits for the engine to complete, with a timeout guard, then routes the read data back to the requester that issued the command.
- Sits between the requesters and the management engine in the top-level network design.

---
 rtl/mdio_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mdio_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_arbiter
//
// Shares a single MII management (MDIO) engine between NREQ requesters.
// One command is accepted at a time in round-robin order, handed to the
// engine over its strobe/stall port, and the engine's completion (or a
// timeout) is routed back to the requester that issued the command.
//
// Handshakes:
//   requester side : a command transfers in the cycle where
//                    i_req_valid[k] && o_req_ready[k]. o_req_ready is only
//                    ever raised in IDLE, for the single granted requester.
//                    Dropping valid before ready withdraws the command.
//   engine side    : a command transfers in the cycle where
//                    o_mng_stb && !i_mng_stall. Completion is the one-cycle
//                    i_mng_done pulse, honoured only while waiting for it.
//   response side  : o_rsp_valid[owner] is a one-cycle pulse; there is no
//                    back-pressure. o_rsp_rdata/o_rsp_err hold until the
//                    next response.
//
// Ports:
//   i_clk, i_nreset        clock, asynchronous active-low reset
//   i_req_valid/o_req_ready per-requester command handshake
//   i_req_write/phy/reg/wdata per-requester packed command fields
//   o_rsp_valid/rdata/err  completion back to the owning requester
//   o_mng_*/i_mng_*        command and completion port of the MDIO engine
//   o_busy                 high whenever a command is being serviced
//   o_owner                current or most recently granted requester
//
// The FSM state is visible as the signal 'state' for observation.
// -----------------------------------------------------------------------------
module mdio_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 20000,
   parameter int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_nreset,
   input  logic [NREQ-1:0]      i_req_valid,
   output logic [NREQ-1:0]      o_req_ready,
   input  logic [NREQ-1:0]      i_req_write,
   input  logic [NREQ*5-1:0]    i_req_phy,
   input  logic [NREQ*5-1:0]    i_req_reg,
   input  logic [NREQ*16-1:0]   i_req_wdata,
   output logic [NREQ-1:0]      o_rsp_valid,
   output logic [15:0]          o_rsp_rdata,
   output logic                 o_rsp_err,
   output logic                 o_mng_stb,
   output logic                 o_mng_is_write,
   output logic [4:0]           o_mng_phys_addr,
   output logic [4:0]           o_mng_reg_addr,
   output logic [15:0]          o_mng_data,
   input  logic                 i_mng_stall,
   input  logic                 i_mng_done,
   input  logic [15:0]          i_mng_rdata,
   output logic                 o_busy,
   output logic [IDX_W-1:0]     o_owner
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [IDX_W-1:0] last_grant;
   logic [CNT_W-1:0] cnt;

   // Round-robin search: scan from last_grant+1 upward, wrapping. The inner
   // loop keeps every vector index a constant so no runtime index is needed.
   logic             grant_found;
   logic [IDX_W-1:0] grant_idx;
   logic [NREQ-1:0]  grant_onehot;
   logic             g_write;
   logic [4:0]       g_phy;
   logic [4:0]       g_reg;
   logic [15:0]      g_wdata;
   int               k;

   always_comb begin
      grant_found  = 1'b0;
      grant_idx    = '0;
      grant_onehot = '0;
      k            = 0;
      for (int i = 1; i <= NREQ; i++) begin
         k = (int'(last_grant) + i) % NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && (j == k) && i_req_valid[j]) begin
               grant_found     = 1'b1;
               grant_idx       = IDX_W'(j);
               grant_onehot[j] = 1'b1;
            end
         end
      end
   end

   // Command fields of the granted requester.
   always_comb begin
      g_write = 1'b0;
      g_phy   = '0;
      g_reg   = '0;
      g_wdata = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (grant_onehot[j]) begin
            g_write = i_req_write[j];
            g_phy   = i_req_phy[j*5 +: 5];
            g_reg   = i_req_reg[j*5 +: 5];
            g_wdata = i_req_wdata[j*16 +: 16];
         end
      end
   end

   // Ready is withheld while reset is asserted so no requester believes a
   // command was taken that the held-in-reset datapath never latched.
   always_comb begin
      o_req_ready = '0;
      o_rsp_valid = '0;
      for (int j = 0; j < NREQ; j++) begin
         o_req_ready[j] = i_nreset && (state == ST_IDLE) && grant_onehot[j];
         o_rsp_valid[j] = (state == ST_RESP) && (o_owner == IDX_W'(j));
      end
   end

   assign o_mng_stb = (state == ST_ISSUE);
   assign o_busy    = (state != ST_IDLE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_found) state_nxt = ST_ISSUE;
         ST_ISSUE: if (!i_mng_stall) state_nxt = ST_WAIT;
         // Done is tested first so a done on the final cycle is not an error.
         ST_WAIT:  if (i_mng_done || (cnt == CNT_LAST)) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         last_grant      <= IDX_W'(NREQ - 1);
         o_owner         <= '0;
         o_mng_is_write  <= 1'b0;
         o_mng_phys_addr <= '0;
         o_mng_reg_addr  <= '0;
         o_mng_data      <= '0;
         cnt             <= '0;
         o_rsp_rdata     <= '0;
         o_rsp_err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_found) begin
                  last_grant      <= grant_idx;
                  o_owner         <= grant_idx;
                  o_mng_is_write  <= g_write;
                  o_mng_phys_addr <= g_phy;
                  o_mng_reg_addr  <= g_reg;
                  o_mng_data      <= g_wdata;
               end
            end
            ST_ISSUE: begin
               if (!i_mng_stall) cnt <= '0;
            end
            ST_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (i_mng_done) begin
                  o_rsp_rdata <= o_mng_is_write ? 16'h0000 : i_mng_rdata;
                  o_rsp_err   <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  o_rsp_rdata <= 16'h0000;
                  o_rsp_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mdio_arbiter
//
// Directed bench for mdio_arbiter with NREQ = 2 and TIMEOUT = 100. Each
// scenario task drives the requesters and a hand-played engine, and compares
// outputs against hand-computed values. Inputs change 2 time units after the
// rising edge; outputs are compared 1 unit later, well away from any edge.
// -----------------------------------------------------------------------------
module tb_mdio_arbiter;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 100;
   localparam int IDX_W   = 1;

   // ------------------------------------------------- clock / reset block
   logic i_clk = 1'b0;
   logic i_nreset;
   always #5 i_clk = ~i_clk;

   logic [NREQ-1:0]    i_req_valid;
   logic [NREQ-1:0]    o_req_ready;
   logic [NREQ-1:0]    i_req_write;
   logic [NREQ*5-1:0]  i_req_phy;
   logic [NREQ*5-1:0]  i_req_reg;
   logic [NREQ*16-1:0] i_req_wdata;
   logic [NREQ-1:0]    o_rsp_valid;
   logic [15:0]        o_rsp_rdata;
   logic               o_rsp_err;
   logic               o_mng_stb;
   logic               o_mng_is_write;
   logic [4:0]         o_mng_phys_addr;
   logic [4:0]         o_mng_reg_addr;
   logic [15:0]        o_mng_data;
   logic               i_mng_stall;
   logic               i_mng_done;
   logic [15:0]        i_mng_rdata;
   logic               o_busy;
   logic [IDX_W-1:0]   o_owner;

   int checks   = 0;
   int failures = 0;

   mdio_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)) dut (
      .i_clk           (i_clk),
      .i_nreset        (i_nreset),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .i_req_write     (i_req_write),
      .i_req_phy       (i_req_phy),
      .i_req_reg       (i_req_reg),
      .i_req_wdata     (i_req_wdata),
      .o_rsp_valid     (o_rsp_valid),
      .o_rsp_rdata     (o_rsp_rdata),
      .o_rsp_err       (o_rsp_err),
      .o_mng_stb       (o_mng_stb),
      .o_mng_is_write  (o_mng_is_write),
      .o_mng_phys_addr (o_mng_phys_addr),
      .o_mng_reg_addr  (o_mng_reg_addr),
      .o_mng_data      (o_mng_data),
      .i_mng_stall     (i_mng_stall),
      .i_mng_done      (i_mng_done),
      .i_mng_rdata     (i_mng_rdata),
      .o_busy          (o_busy),
      .o_owner         (o_owner)
   );

   // -------------------------------------------------------- driver tasks
   task automatic step();
      @(posedge i_clk);
      #2;
   endtask

   task automatic clear_inputs();
      i_req_valid = '0;
      i_req_write = '0;
      i_req_phy   = '0;
      i_req_reg   = '0;
      i_req_wdata = '0;
      i_mng_stall = 1'b0;
      i_mng_done  = 1'b0;
      i_mng_rdata = '0;
   endtask

   // Leaves the bench 2 units after a rising edge, reset released, DUT idle.
   task automatic apply_reset();
      clear_inputs();
      i_nreset = 1'b0;
      repeat (3) step();
      i_nreset = 1'b1;
   endtask

   // ---------------------------------------------------------- scenarios
   task automatic test_reset();
      clear_inputs();
      i_nreset = 1'b0;
      #1;
      checks++;
      if ({o_req_ready, o_rsp_valid, o_mng_stb, o_busy, o_owner, o_rsp_err} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl: ready=%b rsp_valid=%b stb=%b busy=%b owner=%0d err=%b, all required 0",
                  o_req_ready, o_rsp_valid, o_mng_stb, o_busy, o_owner, o_rsp_err);
      end
      checks++;
      if ({o_mng_is_write, o_mng_phys_addr, o_mng_reg_addr, o_mng_data, o_rsp_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_data: wr=%b phy=%h reg=%h data=%h rdata=%h, all required 0",
                  o_mng_is_write, o_mng_phys_addr, o_mng_reg_addr, o_mng_data, o_rsp_rdata);
      end
      repeat (2) step();
      i_nreset = 1'b1;
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_mng_stb !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: busy=%b stb=%b, required 0 0", o_busy, o_mng_stb);
      end
   endtask

   task automatic test_single_read();
      int stb_cnt;
      int bad;
      apply_reset();
      i_req_valid[0]    = 1'b1;
      i_req_write[0]    = 1'b0;
      i_req_phy[4:0]    = 5'h10;
      i_req_reg[4:0]    = 5'h19;
      i_mng_stall       = 1'b1;
      #1;
      checks++;
      if (o_req_ready !== 2'b01) begin
         failures++;
         $display("FAIL single_ready: got %b, required 01", o_req_ready);
      end
      step();
      i_req_valid = '0;
      stb_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) i_mng_stall = 1'b0;
         #1;
         if (o_mng_stb === 1'b1) stb_cnt++;
         if (i == 0) begin
            checks++;
            if (o_mng_phys_addr !== 5'h10 || o_mng_reg_addr !== 5'h19 ||
                o_mng_is_write !== 1'b0 || o_owner !== 1'b0) begin
               failures++;
               $display("FAIL single_fields: phy=%h reg=%h wr=%b owner=%0d, required 10 19 0 0",
                        o_mng_phys_addr, o_mng_reg_addr, o_mng_is_write, o_owner);
            end
         end
         step();
      end
      #1;
      checks++;
      if (stb_cnt != 4 || o_mng_stb !== 1'b0) begin
         failures++;
         $display("FAIL single_stb_len: high %0d cycles, now %b, required 4 cycles then 0",
                  stb_cnt, o_mng_stb);
      end
      bad = 0;
      for (int j = 0; j < 49; j++) begin
         if (j != 0) #1;
         if (o_rsp_valid !== 2'b00 || o_busy !== 1'b1) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL single_wait: %0d bad wait cycles, required 0", bad);
      end
      i_mng_done  = 1'b1;
      i_mng_rdata = 16'hBEEF;
      step();
      i_mng_done  = 1'b0;
      i_mng_rdata = 16'h0000;
      #1;
      checks++;
      if (o_rsp_valid !== 2'b01 || o_rsp_rdata !== 16'hBEEF || o_rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL single_rsp: valid=%b rdata=%h err=%b, required 01 BEEF 0",
                  o_rsp_valid, o_rsp_rdata, o_rsp_err);
      end
      step();
      #1;
      checks++;
      if (o_rsp_valid !== 2'b00 || o_busy !== 1'b0 || o_rsp_rdata !== 16'hBEEF) begin
         failures++;
         $display("FAIL single_after: valid=%b busy=%b rdata=%h, required 00 0 BEEF",
                  o_rsp_valid, o_busy, o_rsp_rdata);
      end
   endtask

   task automatic test_round_robin();
      logic        exp;
      logic [1:0]  exp_oh;
      logic [15:0] exp_rd;
      int          grants0;
      int          grants1;
      apply_reset();
      i_req_valid      = 2'b11;
      i_req_write      = 2'b10;
      i_req_phy        = {5'd3, 5'd1};
      i_req_reg        = {5'd4, 5'd2};
      i_req_wdata      = {16'h5A5A, 16'h0000};
      exp     = 1'b0;
      grants0 = 0;
      grants1 = 0;
      for (int n = 0; n < 8; n++) begin
         exp_oh = exp ? 2'b10 : 2'b01;
         #1;
         checks++;
         if (o_req_ready !== exp_oh) begin
            failures++;
            $display("FAIL rr_ready[%0d]: got %b, required %b", n, o_req_ready, exp_oh);
         end
         if (o_req_ready === 2'b01) grants0++;
         if (o_req_ready === 2'b10) grants1++;
         step();
         #1;
         checks++;
         if (o_mng_stb !== 1'b1 || o_owner !== exp ||
             o_mng_phys_addr !== (exp ? 5'd3 : 5'd1) || o_mng_is_write !== exp) begin
            failures++;
            $display("FAIL rr_issue[%0d]: stb=%b owner=%0d phy=%0d wr=%b, required 1 %0d %0d %b",
                     n, o_mng_stb, o_owner, o_mng_phys_addr, o_mng_is_write,
                     exp, exp ? 3 : 1, exp);
         end
         step();                        // accepted; now first wait cycle
         step();                        // second wait cycle
         i_mng_done  = 1'b1;
         i_mng_rdata = 16'h1000 + 16'(n);
         step();
         i_mng_done  = 1'b0;
         exp_rd = exp ? 16'h0000 : (16'h1000 + 16'(n));
         #1;
         checks++;
         if (o_rsp_valid !== exp_oh || o_rsp_rdata !== exp_rd || o_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rr_rsp[%0d]: valid=%b rdata=%h err=%b, required %b %h 0",
                     n, o_rsp_valid, o_rsp_rdata, o_rsp_err, exp_oh, exp_rd);
         end
         step();
         exp = ~exp;
      end
      i_req_valid = '0;
      checks++;
      if (grants0 != 4 || grants1 != 4) begin
         failures++;
         $display("FAIL rr_fairness: grants %0d/%0d, required 4/4", grants0, grants1);
      end
   endtask

   task automatic test_timeout();
      int bad;
      apply_reset();
      i_req_valid[1]     = 1'b1;
      i_req_write[1]     = 1'b1;
      i_req_phy[9:5]     = 5'h10;
      i_req_reg[9:5]     = 5'h00;
      i_req_wdata[31:16] = 16'hA100;
      #1;
      checks++;
      if (o_req_ready !== 2'b10) begin
         failures++;
         $display("FAIL to_ready: got %b, required 10", o_req_ready);
      end
      step();
      i_req_valid = '0;
      #1;
      checks++;
      if (o_mng_stb !== 1'b1 || o_mng_is_write !== 1'b1 || o_mng_data !== 16'hA100 ||
          o_mng_phys_addr !== 5'h10 || o_mng_reg_addr !== 5'h00 || o_owner !== 1'b1) begin
         failures++;
         $display("FAIL to_issue: stb=%b wr=%b data=%h phy=%h reg=%h owner=%0d, required 1 1 A100 10 00 1",
                  o_mng_stb, o_mng_is_write, o_mng_data, o_mng_phys_addr, o_mng_reg_addr, o_owner);
      end
      step();                           // accept edge
      bad = 0;
      for (int j = 0; j < TIMEOUT; j++) begin
         #1;
         if (o_rsp_valid !== 2'b00 || o_busy !== 1'b1 || o_mng_stb !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL to_wait: %0d bad wait cycles, required 0", bad);
      end
      #1;
      checks++;
      if (o_rsp_valid !== 2'b10 || o_rsp_err !== 1'b1 || o_rsp_rdata !== 16'h0000) begin
         failures++;
         $display("FAIL to_rsp: valid=%b err=%b rdata=%h, required 10 1 0000",
                  o_rsp_valid, o_rsp_err, o_rsp_rdata);
      end
      step();
      i_mng_done  = 1'b1;
      i_mng_rdata = 16'h1234;
      step();
      i_mng_done  = 1'b0;
      #1;
      checks++;
      if (o_rsp_valid !== 2'b00 || o_busy !== 1'b0 || o_rsp_err !== 1'b1 ||
          o_rsp_rdata !== 16'h0000) begin
         failures++;
         $display("FAIL to_late_done: valid=%b busy=%b err=%b rdata=%h, required 00 0 1 0000",
                  o_rsp_valid, o_busy, o_rsp_err, o_rsp_rdata);
      end
   endtask

   task automatic test_done_at_timeout();
      apply_reset();
      i_req_valid[0] = 1'b1;
      i_req_phy[4:0] = 5'h01;
      i_req_reg[4:0] = 5'h01;
      step();
      i_req_valid = '0;
      step();                           // accept edge, first wait cycle
      for (int j = 0; j < TIMEOUT - 1; j++) step();
      #1;
      checks++;
      if (o_rsp_valid !== 2'b00 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL coinc_last_wait: valid=%b busy=%b, required 00 1", o_rsp_valid, o_busy);
      end
      i_mng_done  = 1'b1;
      i_mng_rdata = 16'hC0DE;
      step();
      i_mng_done  = 1'b0;
      #1;
      checks++;
      if (o_rsp_valid !== 2'b01 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 16'hC0DE) begin
         failures++;
         $display("FAIL coinc_rsp: valid=%b err=%b rdata=%h, required 01 0 C0DE",
                  o_rsp_valid, o_rsp_err, o_rsp_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      apply_reset();
      i_req_valid[0] = 1'b1;
      i_req_phy[4:0] = 5'h02;
      i_req_reg[4:0] = 5'h03;
      step();
      i_req_valid = '0;
      step();                           // accept
      step();
      #2;
      i_nreset = 1'b0;
      #1;
      checks++;
      if (o_mng_stb !== 1'b0 || o_busy !== 1'b0 || o_rsp_valid !== 2'b00 ||
          o_req_ready !== 2'b00 || o_owner !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_async: stb=%b busy=%b valid=%b ready=%b owner=%0d, required 0 0 00 00 0",
                  o_mng_stb, o_busy, o_rsp_valid, o_req_ready, o_owner);
      end
      i_mng_done = 1'b1;
      step();
      i_mng_done = 1'b0;
      step();
      i_nreset = 1'b1;
      i_mng_done  = 1'b1;
      i_mng_rdata = 16'h7777;
      bad = 0;
      for (int j = 0; j < 5; j++) begin
         step();
         i_mng_done = 1'b0;
         #1;
         if (o_rsp_valid !== 2'b00 || o_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL rstmid_no_rsp: %0d cycles with activity, required 0", bad);
      end
      i_req_valid = 2'b11;
      #1;
      checks++;
      if (o_req_ready !== 2'b01) begin
         failures++;
         $display("FAIL rstmid_first_grant: got %b, required 01", o_req_ready);
      end
      i_req_valid = '0;
   endtask

   task automatic test_withdrawn();
      int bad;
      apply_reset();
      i_req_valid[0] = 1'b1;
      step();
      i_req_valid = '0;
      step();                           // accept, first wait cycle
      step();
      i_req_valid[1] = 1'b1;
      i_req_phy[9:5] = 5'h07;
      #1;
      checks++;
      if (o_req_ready !== 2'b00) begin
         failures++;
         $display("FAIL wd_ready_busy: got %b, required 00", o_req_ready);
      end
      step();
      i_req_valid = '0;
      step();
      i_mng_done  = 1'b1;
      i_mng_rdata = 16'h0042;
      step();
      i_mng_done  = 1'b0;
      #1;
      checks++;
      if (o_rsp_valid !== 2'b01 || o_rsp_rdata !== 16'h0042) begin
         failures++;
         $display("FAIL wd_rsp: valid=%b rdata=%h, required 01 0042", o_rsp_valid, o_rsp_rdata);
      end
      bad = 0;
      for (int j = 0; j < 5; j++) begin
         step();
         #1;
         if (o_req_ready !== 2'b00 || o_busy !== 1'b0 || o_mng_stb !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL wd_no_grant: %0d cycles with a grant, required 0", bad);
      end
   endtask

   // -------------------------------------------------------- main sequence
   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_timeout();
      test_done_at_timeout();
      test_reset_mid();
      test_withdrawn();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
